// File: rtl/vga_timing_pkg.sv
// Shared timing constants and receive-FSM state type for the VGA line timing blocks.
package vga_timing_pkg;

    // Default 640-wide line timing, in pixel-enable cycles
    localparam int unsigned DEF_FRONT_PORCH_TIME = 16;
    localparam int unsigned DEF_SYNC_TIME        = 96;
    localparam int unsigned DEF_BACK_PORCH_TIME  = 48;
    localparam int unsigned DEF_DISPLAY_TIME     = 640;
    localparam int unsigned DEF_LOCK_LINES       = 4;

    typedef enum logic [2:0] {
        s_hunt,
        s_sync,
        s_back_porch,
        s_display,
        s_front_porch
    } t_rx_state;

endpackage

// File: rtl/vga_sync_edge.sv
// Enable-gated edge detector: remembers the last enabled sample of a level and
// flags a rise or fall when the current enabled sample differs from it.
module vga_sync_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clk_en,
    input  logic i_sig,
    output logic o_rise,
    output logic o_fall
);

    logic prev_q;
    logic prev_d;

    // Previous level only advances on enabled samples
    always_comb begin
        prev_d = prev_q;
        if (i_clk_en) begin
            prev_d = i_sig;
        end
    end

    // Previous-sample register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            prev_q <= RESET_VAL;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign o_rise = i_clk_en &  i_sig & ~prev_q;
    assign o_fall = i_clk_en & ~i_sig &  prev_q;

endmodule

// File: rtl/vga_sync_detector.sv
// VGA receive timing detector: measures sync/porch/display segments of an
// incoming sync/blank pair, declares lock after a run of conforming lines and
// supplies the display pixel position while locked.
module vga_sync_detector
    import vga_timing_pkg::*;
#(
    parameter int unsigned FRONT_PORCH_TIME = DEF_FRONT_PORCH_TIME,
    parameter int unsigned SYNC_TIME        = DEF_SYNC_TIME,
    parameter int unsigned BACK_PORCH_TIME  = DEF_BACK_PORCH_TIME,
    parameter int unsigned DISPLAY_TIME     = DEF_DISPLAY_TIME,
    parameter int unsigned LOCK_LINES       = DEF_LOCK_LINES,
    localparam int unsigned COUNTER_WIDTH   =
        $clog2(FRONT_PORCH_TIME + SYNC_TIME + BACK_PORCH_TIME + DISPLAY_TIME)
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_clk_en,
    input  logic                     i_sync,
    input  logic                     i_blank,
    output logic                     o_locked,
    output logic                     o_active,
    output logic [COUNTER_WIDTH-1:0] o_pos,
    output logic                     o_line_start,
    output logic                     o_error
);

    localparam int unsigned GOOD_W = $clog2(LOCK_LINES + 1);

    localparam logic [COUNTER_WIDTH-1:0] FP_LEN   = COUNTER_WIDTH'(FRONT_PORCH_TIME);
    localparam logic [COUNTER_WIDTH-1:0] SYNC_LEN = COUNTER_WIDTH'(SYNC_TIME);
    localparam logic [COUNTER_WIDTH-1:0] BP_LEN   = COUNTER_WIDTH'(BACK_PORCH_TIME);
    localparam logic [COUNTER_WIDTH-1:0] DISP_LEN = COUNTER_WIDTH'(DISPLAY_TIME);
    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE  = COUNTER_WIDTH'(1);
    localparam logic [GOOD_W-1:0]        LOCK_CNT = GOOD_W'(LOCK_LINES);
    localparam logic [GOOD_W-1:0]        GOOD_ONE = GOOD_W'(1);

    t_rx_state                state_q, state_d;
    logic [COUNTER_WIDTH-1:0] seg_cnt_q, seg_cnt_d;
    logic [GOOD_W-1:0]        good_lines_q, good_lines_d;
    logic                     locked_q, locked_d;
    logic                     active_q, active_d;
    logic [COUNTER_WIDTH-1:0] pos_q, pos_d;
    logic                     line_start_q, line_start_d;
    logic                     error_q, error_d;

    logic                     viol;
    logic                     sync_rise, sync_fall;
    logic                     blank_rise, blank_fall;

    vga_sync_edge #(.RESET_VAL(1'b0)) u_sync_edge (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_clk_en (i_clk_en),
        .i_sig    (i_sync),
        .o_rise   (sync_rise),
        .o_fall   (sync_fall)
    );

    vga_sync_edge #(.RESET_VAL(1'b1)) u_blank_edge (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_clk_en (i_clk_en),
        .i_sig    (i_blank),
        .o_rise   (blank_rise),
        .o_fall   (blank_fall)
    );

    // Segment FSM, lock tracking and next values of the registered outputs
    always_comb begin
        state_d      = state_q;
        seg_cnt_d    = seg_cnt_q;
        good_lines_d = good_lines_q;
        locked_d     = locked_q;
        active_d     = active_q;
        pos_d        = pos_q;
        line_start_d = 1'b0;
        error_d      = 1'b0;
        viol         = 1'b0;

        if (i_clk_en) begin
            // Timeout fires on the sample that would push seg_cnt past its
            // expected length, so the counter never exceeds it.
            unique case (state_q)
                s_hunt: begin
                    if (sync_rise && i_blank) begin
                        state_d   = s_sync;
                        seg_cnt_d = CNT_ONE;
                    end
                end
                s_sync: begin
                    if (blank_rise || blank_fall) begin
                        viol = 1'b1;
                    end else if (sync_fall) begin
                        viol      = (seg_cnt_q != SYNC_LEN);
                        state_d   = s_back_porch;
                        seg_cnt_d = CNT_ONE;
                    end else if (seg_cnt_q == SYNC_LEN) begin
                        viol = 1'b1;
                    end else begin
                        seg_cnt_d = seg_cnt_q + CNT_ONE;
                    end
                end
                s_back_porch: begin
                    if (sync_rise || sync_fall) begin
                        viol = 1'b1;
                    end else if (blank_fall) begin
                        viol      = (seg_cnt_q != BP_LEN);
                        state_d   = s_display;
                        seg_cnt_d = CNT_ONE;
                    end else if (seg_cnt_q == BP_LEN) begin
                        viol = 1'b1;
                    end else begin
                        seg_cnt_d = seg_cnt_q + CNT_ONE;
                    end
                end
                s_display: begin
                    if (sync_rise || sync_fall) begin
                        viol = 1'b1;
                    end else if (blank_rise) begin
                        viol      = (seg_cnt_q != DISP_LEN);
                        state_d   = s_front_porch;
                        seg_cnt_d = CNT_ONE;
                    end else if (seg_cnt_q == DISP_LEN) begin
                        viol = 1'b1;
                    end else begin
                        seg_cnt_d = seg_cnt_q + CNT_ONE;
                    end
                end
                s_front_porch: begin
                    if (sync_rise) begin
                        viol      = (seg_cnt_q != FP_LEN);
                        state_d   = s_sync;
                        seg_cnt_d = CNT_ONE;
                        if (good_lines_q != LOCK_CNT) begin
                            good_lines_d = good_lines_q + GOOD_ONE;
                        end
                    end else if (seg_cnt_q == FP_LEN) begin
                        viol = 1'b1;
                    end else begin
                        seg_cnt_d = seg_cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d   = s_hunt;
                    seg_cnt_d = '0;
                end
            endcase

            if (i_sync && !i_blank) begin
                viol = 1'b1;
            end

            if (viol) begin
                state_d      = s_hunt;
                seg_cnt_d    = '0;
                good_lines_d = '0;
            end

            locked_d     = !viol && (locked_q || (good_lines_d == LOCK_CNT));
            active_d     = locked_d && (state_d == s_display);
            pos_d        = active_d ? (seg_cnt_d - CNT_ONE) : '0;
            line_start_d = active_d && (state_q != s_display);
            error_d      = viol;
        end
    end

    // State and output registers; pulses drop on any non-enabled cycle
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= s_hunt;
            seg_cnt_q    <= '0;
            good_lines_q <= '0;
            locked_q     <= 1'b0;
            active_q     <= 1'b0;
            pos_q        <= '0;
            line_start_q <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            seg_cnt_q    <= seg_cnt_d;
            good_lines_q <= good_lines_d;
            locked_q     <= locked_d;
            active_q     <= active_d;
            pos_q        <= pos_d;
            line_start_q <= line_start_d;
            error_q      <= error_d;
        end
    end

    assign o_locked     = locked_q;
    assign o_active     = active_q;
    assign o_pos        = pos_q;
    assign o_line_start = line_start_q;
    assign o_error      = error_q;

endmodule

// File: tb/tb_vga_sync_detector.sv
// Self-checking bench for vga_sync_detector: table of whole-line vectors plus
// hand-written timeout, sync-in-display and mid-line reset sequences.
module tb_vga_sync_detector;

    typedef struct {
        int unsigned fp;
        int unsigned sy;
        int unsigned bp;
        int unsigned disp;
        int unsigned gap;       // clocks per enabled sample
        logic        err_first; // o_error after first front-porch sample
        logic        lock_sync; // o_locked after the sync rise sample
        logic        lock_end;  // o_locked after last display sample
        logic        act;       // display samples expected active
        int unsigned n_err;     // o_error cycles during the line
        int unsigned n_ls;      // o_line_start cycles during the line
    } line_vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       sync_in = 1'b0;
    logic       blank_in = 1'b1;
    logic       locked, active, line_start, error;
    logic [9:0] pos;

    int unsigned tests = 0;
    int unsigned fails = 0;
    int unsigned gap = 1;
    int unsigned err_total = 0;
    int unsigned ls_total = 0;

    logic       s_err, s_ls, s_act, s_locked;
    logic [9:0] s_pos;

    line_vec_t vecs [13];

    vga_sync_detector #(
        .FRONT_PORCH_TIME (16),
        .SYNC_TIME        (96),
        .BACK_PORCH_TIME  (48),
        .DISPLAY_TIME     (640),
        .LOCK_LINES       (4)
    ) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_clk_en     (en),
        .i_sync       (sync_in),
        .i_blank      (blank_in),
        .o_locked     (locked),
        .o_active     (active),
        .o_pos        (pos),
        .o_line_start (line_start),
        .o_error      (error)
    );

    always #5 clk = ~clk;

    // Count pulse cycles on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (error === 1'b1)      err_total++;
        if (line_start === 1'b1) ls_total++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, tests %0d", tests);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One enabled sample; outputs are snapshotted right after its edge
    task automatic smp(input logic s, input logic b);
        sync_in  = s;
        blank_in = b;
        en       = 1'b1;
        @(posedge clk);
        #1;
        s_err    = error;
        s_ls     = line_start;
        s_act    = active;
        s_pos    = pos;
        s_locked = locked;
        en       = 1'b0;
        for (int unsigned g = 1; g < gap; g++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_line(input line_vec_t v);
        int unsigned bad;
        int unsigned e0;
        int unsigned l0;
        bad = 0;
        gap = v.gap;
        e0  = err_total;
        l0  = ls_total;
        for (int unsigned i = 0; i < v.fp; i++) begin
            smp(1'b0, 1'b1);
            if (i == 0) check("err_first", 32'(s_err), 32'(v.err_first));
        end
        for (int unsigned i = 0; i < v.sy; i++) begin
            smp(1'b1, 1'b1);
            if (i == 0) check("lock_at_sync", 32'(s_locked), 32'(v.lock_sync));
        end
        for (int unsigned i = 0; i < v.bp; i++) smp(1'b0, 1'b1);
        for (int unsigned i = 0; i < v.disp; i++) begin
            smp(1'b0, 1'b0);
            if (s_act !== v.act || s_pos !== (v.act ? 10'(i) : 10'd0)) bad++;
        end
        check("pos_sequence_errors", bad, 0);
        check("lock_end", 32'(s_locked), 32'(v.lock_end));
        check("error_pulses", err_total - e0, v.n_err);
        check("line_start_pulses", ls_total - l0, v.n_ls);
    endtask

    task automatic relock();
        for (int unsigned k = 0; k < 5; k++) run_line(vecs[k]);
        check("relocked", 32'(locked), 1);
    endtask

    initial begin
        int unsigned bad;
        int unsigned e0;

        //          fp  sy  bp  disp gap ef  ls  le  act nerr nls
        vecs[0]  = '{16, 96, 48, 640, 1, 0, 0, 0, 0, 0, 0};
        vecs[1]  = '{16, 96, 48, 640, 1, 0, 0, 0, 0, 0, 0};
        vecs[2]  = '{16, 96, 48, 640, 1, 0, 0, 0, 0, 0, 0};
        vecs[3]  = '{16, 96, 48, 640, 1, 0, 0, 0, 0, 0, 0};
        vecs[4]  = '{16, 96, 48, 640, 1, 0, 1, 1, 1, 0, 1};
        vecs[5]  = '{16, 96, 48, 639, 1, 0, 1, 1, 1, 0, 1};
        vecs[6]  = '{16, 96, 48, 640, 1, 1, 0, 0, 0, 1, 0};
        vecs[7]  = '{16, 96, 48, 640, 1, 0, 0, 0, 0, 0, 0};
        vecs[8]  = '{16, 96, 48, 640, 1, 0, 0, 0, 0, 0, 0};
        vecs[9]  = '{16, 96, 48, 640, 1, 0, 0, 0, 0, 0, 0};
        vecs[10] = '{16, 96, 48, 640, 1, 0, 1, 1, 1, 0, 1};
        vecs[11] = '{16, 96, 48, 640, 2, 0, 1, 1, 1, 0, 1};
        vecs[12] = '{16, 96, 48, 640, 3, 0, 1, 1, 1, 0, 1};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_locked", 32'(locked), 0);
        check("rst_active", 32'(active), 0);
        check("rst_pos", 32'(pos), 0);
        check("rst_line_start", 32'(line_start), 0);
        check("rst_error", 32'(error), 0);
        rst = 1'b0;

        // Acquisition, short display line, relock, enable 1-in-2 and 1-in-3
        for (int unsigned k = 0; k < 13; k++) run_line(vecs[k]);

        // Sync held high for 200 samples while locked
        gap = 1;
        bad = 0;
        e0  = err_total;
        for (int unsigned i = 0; i < 16; i++) smp(1'b0, 1'b1);
        for (int unsigned k = 1; k <= 200; k++) begin
            smp(1'b1, 1'b1);
            if (k == 97) begin
                check("timeout_error", 32'(s_err), 1);
                check("timeout_unlock", 32'(s_locked), 0);
            end else if (s_err !== 1'b0) begin
                bad++;
            end
        end
        check("timeout_stray_errors", bad, 0);
        check("timeout_error_count", err_total - e0, 1);
        relock();

        // Sync asserted during display while locked
        gap = 1;
        for (int unsigned i = 0; i < 16; i++) smp(1'b0, 1'b1);
        for (int unsigned i = 0; i < 96; i++) smp(1'b1, 1'b1);
        for (int unsigned i = 0; i < 48; i++) smp(1'b0, 1'b1);
        for (int unsigned i = 0; i < 100; i++) smp(1'b0, 1'b0);
        check("pre_viol_pos", 32'(s_pos), 99);
        smp(1'b1, 1'b0);
        check("sync_in_disp_error", 32'(s_err), 1);
        check("sync_in_disp_active", 32'(s_act), 0);
        check("sync_in_disp_locked", 32'(s_locked), 0);
        smp(1'b0, 1'b0);
        check("error_single_pulse", 32'(s_err), 0);
        relock();

        // Reset mid-display while locked
        gap = 1;
        for (int unsigned i = 0; i < 16; i++) smp(1'b0, 1'b1);
        for (int unsigned i = 0; i < 96; i++) smp(1'b1, 1'b1);
        for (int unsigned i = 0; i < 48; i++) smp(1'b0, 1'b1);
        for (int unsigned i = 0; i < 300; i++) smp(1'b0, 1'b0);
        check("pre_reset_active", 32'(s_act), 1);
        check("pre_reset_pos", 32'(s_pos), 299);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rst_locked", 32'(locked), 0);
        check("mid_rst_active", 32'(active), 0);
        check("mid_rst_pos", 32'(pos), 0);
        check("mid_rst_line_start", 32'(line_start), 0);
        check("mid_rst_error", 32'(error), 0);
        bad = 0;
        for (int unsigned i = 0; i < 340; i++) begin
            smp(1'b0, 1'b0);
            if (s_act !== 1'b0 || s_err !== 1'b0) bad++;
        end
        check("post_rst_idle", bad, 0);
        relock();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
